// File: rtl/addsub_pkg.sv
// Shared types and helpers for the chunk-serial adder/subtractor.
package addsub_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   // Width of the chunk index register; a single-chunk build still needs one bit.
   function automatic int idx_width(input int nchunk);
      return (nchunk > 1) ? $clog2(nchunk) : 1;
   endfunction

endpackage

// File: rtl/addsub_chunk.sv
// Combinational CHUNK-bit ripple of full adders; also exposes the carry into the top bit.
module addsub_chunk #(
   parameter int CHUNK = 2
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             cin,
   output logic [CHUNK-1:0] s,
   output logic             cout,
   output logic             c_msb_in
);

   logic [CHUNK:0] c;

   assign c[0] = cin;

   for (genvar i = 0; i < CHUNK; i++) begin : g_fa
      assign s[i]   = a[i] ^ b[i] ^ c[i];
      assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
   end

   assign cout     = c[CHUNK];
   assign c_msb_in = c[CHUNK-1];

endmodule

// File: rtl/addsub_serial_pn.sv
// Multi-cycle add/subtract: WIDTH-bit operands consumed CHUNK bits per cycle, LSB chunk first,
// with valid/ready handshakes on both sides.
module addsub_serial_pn
   import addsub_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CHUNK = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int IDXW   = idx_width(NCHUNK);
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
   logic [IDXW-1:0]  idx_q, idx_d;
   logic             carry_q, carry_d;
   logic             cout_q, cout_d, ovf_q, ovf_d;
   logic             out_valid_q, out_valid_d, in_ready_q, in_ready_d;

   logic [CHUNK-1:0] ch_s;
   logic             ch_cout, ch_cmsb;

   // Operands shift right each RUN cycle, so the active chunk is always the low CHUNK bits.
   addsub_chunk #(.CHUNK(CHUNK)) u_chunk (
      .a        (a_q[CHUNK-1:0]),
      .b        (b_q[CHUNK-1:0]),
      .cin      (carry_q),
      .s        (ch_s),
      .cout     (ch_cout),
      .c_msb_in (ch_cmsb)
   );

   always_comb begin
      state_d     = state_q;
      a_d         = a_q;
      b_d         = b_q;
      sum_d       = sum_q;
      idx_d       = idx_q;
      carry_d     = carry_q;
      cout_d      = cout_q;
      ovf_d       = ovf_q;
      out_valid_d = out_valid_q;
      in_ready_d  = in_ready_q;
      case (state_q)
         IDLE: begin
            if (in_valid && in_ready_q) begin
               // Subtraction is A + ~B + 1: invert B now, inject the +1 as the first carry.
               a_d        = a;
               b_d        = b ^ {WIDTH{sub}};
               carry_d    = sub;
               idx_d      = '0;
               sum_d      = '0;
               in_ready_d = 1'b0;
               state_d    = RUN;
            end
         end
         RUN: begin
            sum_d[int'(idx_q)*CHUNK +: CHUNK] = ch_s;
            a_d     = a_q >> CHUNK;
            b_d     = b_q >> CHUNK;
            carry_d = ch_cout;
            idx_d   = idx_q + IDXW'(1);
            if (idx_q == LAST_IDX) begin
               cout_d      = ch_cout;
               ovf_d       = ch_cmsb ^ ch_cout;
               out_valid_d = 1'b1;
               idx_d       = '0;
               state_d     = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         a_q         <= '0;
         b_q         <= '0;
         sum_q       <= '0;
         idx_q       <= '0;
         carry_q     <= 1'b0;
         cout_q      <= 1'b0;
         ovf_q       <= 1'b0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         sum_q       <= sum_d;
         idx_q       <= idx_d;
         carry_q     <= carry_d;
         cout_q      <= cout_d;
         ovf_q       <= ovf_d;
         out_valid_q <= out_valid_d;
         in_ready_q  <= in_ready_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign sum       = sum_q;
   assign cout      = cout_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_addsub_serial_pn.sv
// Scoreboard bench for addsub_serial_pn at CHUNK = 2, 1 and 8 (WIDTH = 8).
module tb_addsub_serial_pn;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic       in_valid[3], in_ready[3], sub_i[3];
   logic       out_valid[3], out_ready[3], cout_o[3], ovf_o[3];
   logic [7:0] a_i[3], b_i[3], sum_o[3];

   for (genvar g = 0; g < 3; g++) begin : g_dut
      addsub_serial_pn #(.WIDTH(8), .CHUNK(g == 0 ? 2 : (g == 1 ? 1 : 8))) dut (
         .clk       (clk),
         .rst_n     (rst_n),
         .in_valid  (in_valid[g]),
         .in_ready  (in_ready[g]),
         .a         (a_i[g]),
         .b         (b_i[g]),
         .sub       (sub_i[g]),
         .out_valid (out_valid[g]),
         .out_ready (out_ready[g]),
         .sum       (sum_o[g]),
         .cout      (cout_o[g]),
         .ovf       (ovf_o[g])
      );
   end

   typedef struct {
      logic [7:0] s;
      logic       c;
      logic       o;
      int         acc;
   } exp_t;

   exp_t sb[3][$];
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fails = 0;
   bit   done = 1'b0;
   bit   finalized = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic int nch(input int g);
      return (g == 0) ? 4 : ((g == 1) ? 8 : 1);
   endfunction

   function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fails++;
         $display("FAIL %s: actual %h required %h", nm, act, req);
      end
   endfunction

   function automatic exp_t golden(input logic [7:0] x, input logic [7:0] y, input logic s);
      exp_t       e;
      logic [8:0] r;
      if (s) begin
         r   = {1'b0, x} - {1'b0, y};
         e.c = (x >= y);
         e.o = (x[7] != y[7]) && (r[7] != x[7]);
      end else begin
         r   = {1'b0, x} + {1'b0, y};
         e.c = r[8];
         e.o = (x[7] == y[7]) && (r[7] != x[7]);
      end
      e.s   = r[7:0];
      e.acc = 0;
      return e;
   endfunction

   // Monitor: the only process that compares and counts.
   logic prev_ov[3], prev_hs[3];
   bit   prev_rst;
   initial begin
      prev_rst = 1'b0;
      for (int g = 0; g < 3; g++) begin
         prev_ov[g] = 1'b0;
         prev_hs[g] = 1'b0;
      end
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            for (int g = 0; g < 3; g++) begin
               sb[g].delete();
               prev_ov[g] = 1'b0;
               prev_hs[g] = 1'b0;
            end
            prev_rst = 1'b1;
         end else begin
            for (int g = 0; g < 3; g++) begin
               if (prev_rst)
                  chk($sformatf("reset_state dut%0d {in_ready,out_valid,sum,cout,ovf}", g),
                      32'({in_ready[g], out_valid[g], sum_o[g], cout_o[g], ovf_o[g]}),
                      32'({1'b1, 1'b0, 8'h00, 1'b0, 1'b0}));
               if (prev_hs[g])
                  chk($sformatf("in_ready_after_handshake dut%0d", g), 32'(in_ready[g]), 32'd1);
               if (out_valid[g]) begin
                  if (sb[g].size() == 0) begin
                     chk($sformatf("unexpected_output dut%0d queue_size", g), 32'd0, 32'd1);
                  end else begin
                     chk($sformatf("result dut%0d {sum,cout,ovf}", g),
                         32'({sum_o[g], cout_o[g], ovf_o[g]}),
                         32'({sb[g][0].s, sb[g][0].c, sb[g][0].o}));
                     chk($sformatf("in_ready_low_in_done dut%0d", g), 32'(in_ready[g]), 32'd0);
                     if (!prev_ov[g])
                        chk($sformatf("latency dut%0d", g), 32'(cyc - sb[g][0].acc), 32'(nch(g)));
                     if (out_ready[g]) void'(sb[g].pop_front());
                  end
                  prev_hs[g] = out_ready[g];
               end else begin
                  prev_hs[g] = 1'b0;
               end
               prev_ov[g] = out_valid[g];
            end
            prev_rst = 1'b0;
            if (done && !finalized) begin
               for (int g = 0; g < 3; g++)
                  chk($sformatf("leftover_expected dut%0d", g), 32'(sb[g].size()), 32'd0);
               finalized = 1'b1;
            end
         end
      end
   end

   task automatic send(input int g, input logic [7:0] x, input logic [7:0] y, input logic s,
                       input logic [7:0] es, input logic ec, input logic eo);
      int t;
      t = 0;
      a_i[g]      = x;
      b_i[g]      = y;
      sub_i[g]    = s;
      in_valid[g] = 1'b1;
      forever begin
         @(negedge clk);
         if (in_ready[g]) break;
         t++;
         if (t > 200) begin
            $display("FAIL accept_timeout dut%0d: in_ready stuck at %b, required 1", g, in_ready[g]);
            $fatal(1);
         end
      end
      sb[g].push_back('{es, ec, eo, cyc + 1});
      @(posedge clk);
      #1;
      in_valid[g] = 1'b0;
      a_i[g]      = 8'hEE;
      b_i[g]      = 8'h11;
   endtask

   task automatic wait_idle(input int g);
      int t;
      t = 0;
      while (sb[g].size() != 0) begin
         @(negedge clk);
         t++;
         if (t > 200) begin
            $display("FAIL result_timeout dut%0d: %0d pending, required 0", g, sb[g].size());
            $fatal(1);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic rand_ops(input int g, input int n);
      logic [7:0] ra, rb;
      logic       rs;
      exp_t       e;
      for (int i = 0; i < n; i++) begin
         ra = 8'($urandom);
         rb = 8'($urandom);
         rs = 1'($urandom_range(0, 1));
         e  = golden(ra, rb, rs);
         send(g, ra, rb, rs, e.s, e.c, e.o);
      end
      wait_idle(g);
   endtask

   initial begin
      #600000;
      $display("FAIL watchdog: simulation time exceeded, required completion");
      $fatal(1);
   end

   initial begin
      for (int g = 0; g < 3; g++) begin
         in_valid[g]  = 1'b0;
         out_ready[g] = 1'b1;
         a_i[g]       = 8'h00;
         b_i[g]       = 8'h00;
         sub_i[g]     = 1'b0;
      end
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // Directed add/sub vectors (hand-computed results)
      send(0, 8'h3C, 8'h05, 1'b0, 8'h41, 1'b0, 1'b0);
      send(0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
      send(0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
      send(0, 8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0);
      send(0, 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);
      wait_idle(0);

      // Backpressure: hold result 5 cycles while a new request is offered
      out_ready[0] = 1'b0;
      send(0, 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0);
      for (int t = 0; t < 200 && !out_valid[0]; t++) @(negedge clk);
      @(posedge clk);
      #1;
      a_i[0] = 8'hEE; b_i[0] = 8'h11; sub_i[0] = 1'b1; in_valid[0] = 1'b1;
      repeat (5) @(posedge clk);
      #1 in_valid[0] = 1'b0;
      @(posedge clk);
      #1 out_ready[0] = 1'b1;
      send(0, 8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0);
      wait_idle(0);

      // Reset during RUN abandons the op
      send(0, 8'h3C, 8'h05, 1'b0, 8'h41, 1'b0, 1'b0);
      @(posedge clk);
      #1 rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      send(0, 8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0);
      wait_idle(0);

      // Chunk-size sweep
      fork
         send(1, 8'hA5, 8'h5B, 1'b0, 8'h00, 1'b1, 1'b0);
         send(2, 8'hA5, 8'h5B, 1'b0, 8'h00, 1'b1, 1'b0);
      join
      wait_idle(1);
      wait_idle(2);

      fork
         rand_ops(0, 1000);
         rand_ops(1, 300);
         rand_ops(2, 300);
      join

      done = 1'b1;
      for (int t = 0; t < 20 && !finalized; t++) @(posedge clk);
      if (!finalized) begin
         $display("FAIL finalize_timeout: monitor did not finish, required completion");
         $fatal(1);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/addsub_serial_pn.md
Name: addsub_serial_pn

Overview:
Parametrised multi-cycle adder/subtractor; successor to the fixed 2-bit parallel adder. Processes WIDTH-bit operands CHUNK bits per cycle, least-significant chunk first, with a rippled carry register between chunks. Supports add and subtract (two's complement) modes and reports unsigned carry/no-borrow and signed overflow. Uses valid/ready handshakes on input and output; sits between an operand source and a result consumer in the lab datapath.

Parameters:
WIDTH, 8, operand/result width in bits; must be a multiple of CHUNK, ≥ 2
CHUNK, 2, bits processed per cycle; 1 ≤ CHUNK ≤ WIDTH
NCHUNK, WIDTH/CHUNK, derived (localparam), cycles spent in RUN

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  synchronous active-low reset
in_valid  in  1  operands and mode presented
in_ready  out  1  block can accept operands
a  in  WIDTH  operand A
b  in  WIDTH  operand B
sub  in  1  0: A+B, 1: A−B
out_valid  out  1  result registers valid
out_ready  in  1  consumer accepts result
sum  out  WIDTH  result, registered
cout  out  1  add: carry out; sub: 1 = no borrow (A ≥ B unsigned)
ovf  out  1  signed overflow (carry into MSB XOR carry out of MSB)

Behaviour:
- Reset (rst_n=0 at clk edge): state IDLE; sum=0, cout=0, ovf=0, out_valid=0; in_ready=1 the cycle after reset releases; internal operand, carry and chunk-index registers cleared. Reset in RUN or DONE abandons the operation; no result is emitted.
- States: IDLE → RUN → DONE → IDLE.
- IDLE: in_ready=1. On in_valid & in_ready: latch a, b XOR {WIDTH{sub}}, carry ← sub, idx ← 0, clear sum; go to RUN. in_valid with in_ready=0 is ignored, and the source holds.
- RUN: in_ready=0. Each cycle: chunk[idx] of sum ← a_chunk + b_chunk + carry (CHUNK-bit ripple); carry ← chunk carry-out; idx ← idx+1. On the last chunk (idx=NCHUNK−1), capture the carry into MSB and the carry out; set cout=carry out, ovf=carry-in(MSB) XOR carry-out; go to DONE; out_valid=1 from next cycle.
- Latency: out_valid rises exactly NCHUNK cycles after the accepting edge (WIDTH=8, CHUNK=2 → 4 cycles).
- DONE: out_valid=1; sum/cout/ovf held stable until out_ready=1. On out_valid & out_ready: out_valid←0, go to IDLE. in_ready returns to 1 the cycle after the output handshake; there is no same-cycle accept.
- out_ready while not out_valid: no effect. Operand inputs are don't-care outside the accept cycle.
- All arithmetic is modulo 2^WIDTH; sum is never wider than WIDTH.
- CHUNK=WIDTH degenerates to a one-cycle RUN; behaviour otherwise identical.

Decomposition:
- Package addsub_pkg: state enum (IDLE, RUN, DONE), 2-bit encoding; helper function for the chunk-count width (clog2 of NCHUNK, minimum 1).
- Sub-module addsub_chunk (combinational, parameter CHUNK): inputs a, b, cin; outputs s, cout, and c_msb_in (carry into the top bit, used for ovf). It is built as a ripple of full adders, matching the existing gate-level adder style.
- Top handles the FSM, handshakes, operand shift/index and result registers.

Test Plan:
WIDTH=8, CHUNK=2, add 0x3C+0x05, out_ready=1 → out_valid 4 cycles after accept; sum=0x41, cout=0, ovf=0; in_ready high next cycle.
Add 0x7F+0x01 → sum=0x80, cout=0, ovf=1; add 0xFF+0x01 → sum=0x00, cout=1, ovf=0.
Sub 0x05−0x07 → sum=0xFE, cout=0 (borrow), ovf=0; sub 0x80−0x01 → sum=0x7F, cout=1, ovf=1.
Backpressure: out_ready=0 for 5 cycles after out_valid → sum/flags stable, in_ready=0, new in_valid ignored; out_ready=1 → handshake, then the next op is accepted.
Reset mid-RUN (rst_n=0 at cycle 2 of 0x3C+0x05) → out_valid=0, sum=0, in_ready=1 after release; next op 0x10+0x20 yields 0x30 correctly.
Parameter sweep: CHUNK=1 (8-cycle latency) and CHUNK=8 (1-cycle latency) → 0xA5+0x5B gives sum=0x00, cout=1, ovf=0; random add/sub vs golden model, 1000 ops.
